// File: rtl/obi_req_gen.sv
// OBI data-side initiator: issues one request per command, tracks granted transactions in order,
// returns one registered response per rvalid and flags responder protocol violations.
// Optional pre-request random idle cycles are enabled by defining OBI_REQ_RAND_DELAY_EN.
module obi_req_gen #(
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [3:0]    REQ_WMAX,
    // command port
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [3:0]    cmd_be,
    input  logic          cmd_is_cap,
    input  logic [31:0]   cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [7:0]    cmd_flag,
    // OBI request channel
    output logic          data_req,
    output logic          data_we,
    output logic [3:0]    data_be,
    output logic          data_is_cap,
    output logic [31:0]   data_addr,
    output logic [DW-1:0] data_wdata,
    output logic [7:0]    data_flag,
    input  logic          data_gnt,
    // OBI response channel
    input  logic          data_rvalid,
    input  logic [DW-1:0] data_rdata,
    input  logic          data_err,
    // response port
    output logic          rsp_valid,
    output logic          rsp_we,
    output logic [7:0]    rsp_flag,
    output logic [31:0]   rsp_addr,
    output logic [3:0]    rsp_be,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [3:0]    outst_cnt,
    output logic          proto_err
);

    localparam int         PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [4:0] MAX_W = 5'(MAX_OUTST);

`ifdef OBI_REQ_RAND_DELAY_EN
    typedef enum logic [1:0] {IDLE, DELAY, REQ} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ} state_t;
`endif

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [7:0]  flag;
    } trk_t;

    state_t      state;
    trk_t        fifo_mem [MAX_OUTST];
    trk_t        head;
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        fifo_empty;
    logic        grant;
    logic        accept;
    logic        pop;
    logic [4:0]  cnt_inc;
    logic [4:0]  cnt_next;

    assign grant      = data_req && data_gnt;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign pop        = data_rvalid && !fifo_empty;
    assign head       = fifo_mem[rd_ptr[PW-1:0]];

    // Only the grant is credited; an rvalid in the same cycle frees a slot one cycle later.
    assign cnt_inc   = {1'b0, outst_cnt} + {4'b0, grant};
    assign cnt_next  = cnt_inc - {4'b0, pop};
    assign cmd_ready = ((state == IDLE) || ((state == REQ) && data_gnt)) && (cnt_inc < MAX_W);
    assign accept    = cmd_valid && cmd_ready;

`ifdef OBI_REQ_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic [3:0]  delay_cnt;
    logic [3:0]  rand_wait;

    assign rand_wait = 4'(lfsr[7:0] % ({4'b0, REQ_WMAX} + 8'd1));
`else
    logic unused_wmax;
    assign unused_wmax = ^REQ_WMAX;
`endif

    // NOTE: all state is registered with non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            data_req    <= 1'b0;
            data_we     <= 1'b0;
            data_be     <= '0;
            data_is_cap <= 1'b0;
            data_addr   <= '0;
            data_wdata  <= '0;
            data_flag   <= '0;
`ifdef OBI_REQ_RAND_DELAY_EN
            lfsr        <= 16'hACE1;
            delay_cnt   <= '0;
`endif
        end else begin
            if (accept) begin
                data_we     <= cmd_we;
                data_be     <= cmd_be;
                data_is_cap <= cmd_is_cap;
                data_addr   <= cmd_addr;
                data_wdata  <= cmd_wdata;
                data_flag   <= cmd_flag;
            end
`ifdef OBI_REQ_RAND_DELAY_EN
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (accept) begin
                if (rand_wait == 4'd0) begin
                    state    <= REQ;
                    data_req <= 1'b1;
                end else begin
                    state     <= DELAY;
                    data_req  <= 1'b0;
                    delay_cnt <= rand_wait;
                end
            end else begin
                case (state)
                    DELAY: begin
                        if (delay_cnt == 4'd1) begin
                            state    <= REQ;
                            data_req <= 1'b1;
                        end else begin
                            delay_cnt <= delay_cnt - 4'd1;
                        end
                    end
                    REQ: begin
                        if (data_gnt) begin
                            state    <= IDLE;
                            data_req <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
`else
            if (accept) begin
                state    <= REQ;
                data_req <= 1'b1;
            end else if ((state == REQ) && data_gnt) begin
                state    <= IDLE;
                data_req <= 1'b0;
            end
`endif
        end
    end

    // NOTE: the tracking storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            fifo_mem[wr_ptr[PW-1:0]] <= '{we: data_we, be: data_be, addr: data_addr, flag: data_flag};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            outst_cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_flag  <= '0;
            rsp_addr  <= '0;
            rsp_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            outst_cnt <= cnt_next[3:0];
            rsp_valid <= pop;
            if (pop) begin
                rsp_we    <= head.we;
                rsp_flag  <= head.flag;
                rsp_addr  <= head.addr;
                rsp_be    <= head.be;
                rsp_rdata <= head.we ? '0 : data_rdata;
                rsp_err   <= data_err;
            end
            if ((data_gnt && !data_req) || (data_rvalid && fifo_empty) || (cnt_next > MAX_W)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_req_gen.sv
// Self-checking bench for obi_req_gen (default build): directed scenarios plus a randomized phase,
// compared every cycle against a transaction-level model built from queues.
module tb_obi_req_gen;

    localparam int DW        = 32;
    localparam int MAX_OUTST = 4;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic        cap;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  flag;
    } cmd_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [3:0]    REQ_WMAX = 4'd3;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [3:0]    cmd_be = '0;
    logic          cmd_is_cap = 1'b0;
    logic [31:0]   cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [7:0]    cmd_flag = '0;
    logic          data_req;
    logic          data_we;
    logic [3:0]    data_be;
    logic          data_is_cap;
    logic [31:0]   data_addr;
    logic [DW-1:0] data_wdata;
    logic [7:0]    data_flag;
    logic          data_gnt = 1'b0;
    logic          data_rvalid = 1'b0;
    logic [DW-1:0] data_rdata = '0;
    logic          data_err = 1'b0;
    logic          rsp_valid;
    logic          rsp_we;
    logic [7:0]    rsp_flag;
    logic [31:0]   rsp_addr;
    logic [3:0]    rsp_be;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [3:0]    outst_cnt;
    logic          proto_err;

    obi_req_gen #(.DW(DW), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .REQ_WMAX(REQ_WMAX),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_be(cmd_be),
        .cmd_is_cap(cmd_is_cap), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_flag(cmd_flag),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_is_cap(data_is_cap),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_flag(data_flag), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_flag(rsp_flag), .rsp_addr(rsp_addr),
        .rsp_be(rsp_be), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .outst_cnt(outst_cnt), .proto_err(proto_err)
    );

    always #5 clk_i = ~clk_i;

    int   tests = 0;
    int   fails = 0;

    // Reference model: the held request, the in-order list of granted commands, the sticky error.
    cmd_t m_q[$];
    cmd_t m_cmd;
    logic m_req  = 1'b0;
    logic m_perr = 1'b0;
    cmd_t nc     = '0;
    logic acc;
    int   sent;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input logic we, input logic [31:0] addr, input logic [7:0] flag);
        cmd_t r;
        r.we = we; r.be = 4'hF; r.cap = 1'b0; r.addr = addr;
        r.wdata = addr ^ 32'h5555_0000; r.flag = flag;
        return r;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t r;
        r.we = 1'($urandom); r.be = 4'($urandom); r.cap = 1'($urandom);
        r.addr = $urandom; r.wdata = $urandom; r.flag = 8'($urandom);
        return r;
    endfunction

    // One clock cycle: drive inputs, check ready, advance the model, check registered outputs.
    task automatic step(input logic v, input cmd_t c, input logic gnt, input logic rv,
                        input logic [31:0] rd, input logic er, output logic accepted);
        logic exp_ready, grant, pop;
        cmd_t e;
        @(negedge clk_i);
        cmd_valid = v; cmd_we = c.we; cmd_be = c.be; cmd_is_cap = c.cap;
        cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_flag = c.flag;
        data_gnt = gnt; data_rvalid = rv; data_rdata = rd; data_err = er;
        #1;
        exp_ready = (!m_req || gnt) && ((m_q.size() + ((m_req && gnt) ? 1 : 0)) < MAX_OUTST);
        check("cmd_ready", cmd_ready, exp_ready);
        accepted = v && exp_ready;
        grant    = m_req && gnt;
        pop      = rv && (m_q.size() > 0);
        if ((gnt && !m_req) || (rv && (m_q.size() == 0))) m_perr = 1'b1;
        e = nc;
        if (pop) e = m_q.pop_front();
        if (grant) m_q.push_back(m_cmd);
        if (accepted) begin
            m_cmd = c;
            m_req = 1'b1;
        end else if (grant) begin
            m_req = 1'b0;
        end
        @(posedge clk_i); #1;
        check("data_req", data_req, m_req);
        if (m_req)
            check("data_attr", {data_we, data_be, data_is_cap, data_addr, data_wdata, data_flag},
                  {m_cmd.we, m_cmd.be, m_cmd.cap, m_cmd.addr, m_cmd.wdata, m_cmd.flag});
        check("outst_cnt", outst_cnt, m_q.size());
        check("rsp_valid", rsp_valid, pop);
        if (pop)
            check("rsp_fields", {rsp_we, rsp_flag, rsp_addr, rsp_be, rsp_rdata, rsp_err},
                  {e.we, e.flag, e.addr, e.be, (e.we ? 32'h0 : rd), er});
        check("proto_err", proto_err, m_perr);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; cmd_valid = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0;
        @(posedge clk_i); #1;
        check("rst_data", {data_req, data_we, data_be, data_is_cap, data_addr, data_wdata, data_flag}, '0);
        check("rst_outst", outst_cnt, 0);
        check("rst_rsp", {rsp_valid, rsp_we, rsp_flag, rsp_addr, rsp_be, rsp_rdata, rsp_err}, '0);
        check("rst_perr", proto_err, 1'b0);
        m_q.delete(); m_req = 1'b0; m_perr = 1'b0; m_cmd = nc;
        rst_ni = 1'b1;
    endtask

    task automatic drain();
        logic a;
        for (int k = 0; k < 40 && (m_q.size() > 0 || m_req); k++)
            step(1'b0, nc, m_req, m_q.size() > 0, $urandom, 1'b0, a);
    endtask

    initial begin
        do_reset();

        // Single read, immediate grant, response two cycles later
        step(1'b1, mk(1'b0, 32'h100, 8'h5A), 1'b0, 1'b0, 32'h0, 1'b0, acc);
        step(1'b0, nc, 1'b1, 1'b0, 32'h0, 1'b0, acc);
        step(1'b0, nc, 1'b0, 1'b0, 32'h0, 1'b0, acc);
        step(1'b0, nc, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, acc);
        step(1'b0, nc, 1'b0, 1'b0, 32'h0, 1'b0, acc);

        // Grant withheld five cycles while another command waits
        step(1'b1, mk(1'b0, 32'h200, 8'h21), 1'b0, 1'b0, 32'h0, 1'b0, acc);
        for (int i = 0; i < 5; i++)
            step(1'b1, mk(1'b1, 32'h204, 8'h22), 1'b0, 1'b0, 32'h0, 1'b0, acc);
        step(1'b1, mk(1'b1, 32'h204, 8'h22), 1'b1, 1'b0, 32'h0, 1'b0, acc);
        step(1'b0, nc, 1'b1, 1'b1, 32'h1111_2222, 1'b1, acc);
        drain();

        // Credit limit: six commands, no responses until the limit is hit
        sent = 0;
        for (int i = 0; i < 14; i++) begin
            step(sent < 6, mk(1'b0, 32'h300 + 32'(sent * 4), 8'(8'h30 + sent)), m_req,
                 (i == 9), 32'h1234_0000 + 32'(i), 1'b0, acc);
            if (acc) sent++;
        end
        drain();

        // Three writes, then an rvalid coincident with the third grant
        step(1'b1, mk(1'b1, 32'h400, 8'h01), 1'b0, 1'b0, 32'h0, 1'b0, acc);
        step(1'b1, mk(1'b1, 32'h404, 8'h02), 1'b1, 1'b0, 32'h0, 1'b0, acc);
        step(1'b1, mk(1'b1, 32'h408, 8'h03), 1'b1, 1'b0, 32'h0, 1'b0, acc);
        step(1'b0, nc, 1'b1, 1'b1, 32'hAAAA_5555, 1'b0, acc);
        step(1'b0, nc, 1'b0, 1'b1, 32'hBBBB_6666, 1'b1, acc);
        step(1'b0, nc, 1'b0, 1'b1, 32'hCCCC_7777, 1'b0, acc);

        // Randomized legal traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom), rnd_cmd(), m_req ? ($urandom_range(0, 2) != 0) : 1'b0,
                 (m_q.size() > 0) ? 1'($urandom) : 1'b0, $urandom, 1'($urandom), acc);
        drain();

        // Protocol error: rvalid with nothing outstanding, sticky afterwards
        step(1'b0, nc, 1'b0, 1'b1, 32'h9999_9999, 1'b0, acc);
        step(1'b0, nc, 1'b0, 1'b0, 32'h0, 1'b0, acc);
        step(1'b1, mk(1'b0, 32'h500, 8'h50), 1'b0, 1'b0, 32'h0, 1'b0, acc);
        drain();
        do_reset();

        // Protocol error: grant without a request
        step(1'b0, nc, 1'b1, 1'b0, 32'h0, 1'b0, acc);
        step(1'b0, nc, 1'b0, 1'b0, 32'h0, 1'b0, acc);
        do_reset();

        // Reset with two outstanding and one pending
        step(1'b1, mk(1'b0, 32'h600, 8'h61), 1'b0, 1'b0, 32'h0, 1'b0, acc);
        step(1'b1, mk(1'b0, 32'h604, 8'h62), 1'b1, 1'b0, 32'h0, 1'b0, acc);
        step(1'b1, mk(1'b1, 32'h608, 8'h63), 1'b1, 1'b0, 32'h0, 1'b0, acc);
        do_reset();
        step(1'b0, nc, 1'b0, 1'b0, 32'h0, 1'b0, acc);
        step(1'b0, nc, 1'b0, 1'b1, 32'h7777_0000, 1'b0, acc);
        step(1'b0, nc, 1'b0, 1'b0, 32'h0, 1'b0, acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
